// File: rtl/oram_stub_responder.sv
// ORAM backend stand-in: accepts block read/write commands, stores blocks locally and replies after a fixed emulated delay.
// One command at a time; ready/valid on command, write-beat and read-beat channels, read beats hold while stalled.
module oram_stub_responder #(
  parameter int ORAMU         = 32,
  parameter int ORAMB         = 512,
  parameter int FEDWidth      = 64,
  parameter int BECMDWidth    = 2,
  parameter int NumBlocks     = 16,
  parameter int AccessLatency = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [BECMDWidth-1:0] oram_cmd_i,
  input  logic [ORAMU-1:0]      oram_paddr_i,
  input  logic                  oram_cmd_vld_i,
  output logic                  oram_cmd_rdy_o,
  input  logic [FEDWidth-1:0]   oram_din_i,
  input  logic                  oram_din_vld_i,
  output logic                  oram_din_rdy_o,
  output logic [FEDWidth-1:0]   oram_dout_o,
  output logic                  oram_dout_vld_o,
  input  logic                  oram_dout_rdy_i,
  output logic                  busy_o,
  output logic [31:0]           access_count_o
);

  localparam int BEATS  = ORAMB / FEDWidth;
  localparam int IDX_W  = $clog2(NumBlocks);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAT_W  = (AccessLatency > 1) ? $clog2(AccessLatency + 1) : 1;

  localparam logic [BECMDWidth-1:0] CMD_UPDATE  = BECMDWidth'(0);
  localparam logic [BECMDWidth-1:0] CMD_APPEND  = BECMDWidth'(1);
  localparam logic [BECMDWidth-1:0] CMD_READRMV = BECMDWidth'(3);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_SEND = 2'd3;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(AccessLatency);
  localparam logic [LAT_W-1:0]  LAT_ONE   = LAT_W'(1);

  typedef logic [BEATS-1:0][FEDWidth-1:0] blk_t;

  // Returned for any block that has never been written (or was removed).
  localparam blk_t FILL_BLK = {(ORAMB / 32){32'hdeaf1234}};

  function automatic logic is_write(input logic [BECMDWidth-1:0] c);
    return (c == CMD_UPDATE) || (c == CMD_APPEND);
  endfunction

  logic [1:0]            state_q, state_d;
  logic [BECMDWidth-1:0] cmd_q, cmd_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  blk_t                  wbuf_q, wbuf_d;
  blk_t                  rbuf_q, rbuf_d;
  logic [NumBlocks-1:0]  valid_q, valid_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  mem_we;
  logic                  done;
  blk_t                  mem_q [NumBlocks];

  logic unused_addr_bits;
  assign unused_addr_bits = ^oram_paddr_i[ORAMU-1:IDX_W];

  assign oram_cmd_rdy_o  = (state_q == ST_IDLE);
  assign oram_din_rdy_o  = (state_q == ST_RECV);
  assign oram_dout_vld_o = (state_q == ST_SEND);
  assign oram_dout_o     = (state_q == ST_SEND) ? rbuf_q[beat_q] : '0;
  assign busy_o          = (state_q != ST_IDLE);
  assign access_count_o  = cnt_q;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    wbuf_d  = wbuf_q;
    rbuf_d  = rbuf_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (oram_cmd_vld_i) begin
          cmd_d = oram_cmd_i;
          idx_d = oram_paddr_i[IDX_W-1:0];
          if (is_write(oram_cmd_i)) begin
            state_d = ST_RECV;
            beat_d  = '0;
          end else begin
            state_d = ST_WAIT;
            lat_d   = LAT_INIT;
          end
        end
      end

      ST_RECV: begin
        if (oram_din_vld_i) begin
          wbuf_d[beat_q] = oram_din_i;
          if (beat_q == LAST_BEAT) begin
            beat_d         = '0;
            mem_we         = 1'b1;
            valid_d[idx_q] = 1'b1;
            state_d        = ST_WAIT;
            lat_d          = LAT_INIT;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      ST_WAIT: begin
        if (lat_q == LAT_ONE) begin
          lat_d = '0;
          if (is_write(cmd_q)) begin
            state_d = ST_IDLE;
            done    = 1'b1;
          end else begin
            // Snapshot here so a later write to the same index cannot disturb the reply.
            rbuf_d  = valid_q[idx_q] ? mem_q[idx_q] : FILL_BLK;
            beat_d  = '0;
            state_d = ST_SEND;
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end

      default: begin
        if (oram_dout_rdy_i) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = ST_IDLE;
            done    = 1'b1;
            if (cmd_q == CMD_READRMV) begin
              valid_d[idx_q] = 1'b0;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
    endcase

    if (done && (cnt_q != 32'hffff_ffff)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      idx_q   <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      wbuf_q  <= '0;
      rbuf_q  <= '0;
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      wbuf_q  <= wbuf_d;
      rbuf_q  <= rbuf_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Block contents are qualified by valid_q, so the array itself carries no reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[idx_q] <= wbuf_d;
    end
  end

endmodule

// File: doc/oram_stub_responder.md
ORAM_STUB_RESPONDER -- requirements
Module: ORAMStubResponder

Interface
REQ-001 Parameter ORAMU, default 32: program-address width.
REQ-002 Parameter ORAMB, default 512: block width; an integer multiple of FEDWidth and of 32.
REQ-003 Parameter FEDWidth, default 64: data beat width; Beats = ORAMB/FEDWidth.
REQ-004 Parameter BECMDWidth, default 2: command width; BECMD_Update=0, BECMD_Append=1, BECMD_Read=2, BECMD_ReadRmv=3.
REQ-005 Parameter NumBlocks, default 16: storage depth; a power of two, at least 2.
REQ-006 Parameter AccessLatency, default 16: emulated access delay in cycles; at least 1.
REQ-007 Clock  in  1  single clock for all state.
REQ-008 Reset  in  1  asynchronous, active-high reset.
REQ-009 ORAMCommand  in  BECMDWidth  request command.
REQ-010 ORAMPAddr  in  ORAMU  request block address.
REQ-011 ORAMCommandValid / ORAMCommandReady  in / out  1 each  command handshake.
REQ-012 ORAMDataIn  in  FEDWidth  write-data beat; ORAMDataInValid in 1 / ORAMDataInReady out 1.
REQ-013 ORAMDataOut  out  FEDWidth  read-data beat; ORAMDataOutValid out 1 / ORAMDataOutReady in 1.
REQ-014 Busy  out  1  high in every state except ST_Idle.
REQ-015 AccessCount  out  32  number of completed accesses, saturating at 2^32-1.

Function
REQ-016 FSM states: ST_Idle, ST_RecvData, ST_Wait, ST_SendData.
REQ-017 ORAMCommandReady = 1 only in ST_Idle; a command transfers on Valid&Ready, and its command and address are latched.
REQ-018 Index = ORAMPAddr[log2(NumBlocks)-1:0]; upper address bits are ignored.
REQ-019 Update/Append transfer: ST_Idle -> ST_RecvData.
REQ-020 Read/ReadRmv transfer: ST_Idle -> ST_Wait.
REQ-021 ST_RecvData: ORAMDataInReady=1; each beat on DataInValid&Ready fills slice [k*FEDWidth +: FEDWidth], with beat 0 least significant.
REQ-022 ST_RecvData: after beat Beats-1, write the block to storage[Index], set Valid[Index], and go to ST_Wait.
REQ-023 ORAMDataInReady = 0 outside ST_RecvData; beats offered then are not consumed.
REQ-024 ST_Wait: a down-counter is loaded with AccessLatency on entry; the state exits on the cycle the count reaches 1, so ST_Wait lasts exactly AccessLatency cycles.
REQ-025 ST_Wait exit for writes: go to ST_Idle and increment AccessCount.
REQ-026 ST_Wait exit for reads: snapshot the output block and go to ST_SendData.
REQ-027 Output block = storage[Index] if Valid[Index], else {ORAMB/32{32'hdeaf1234}}.
REQ-028 ST_SendData: ORAMDataOutValid=1, ORAMDataOut = beat k of the snapshot (LSB first); k advances only on Valid&Ready; DataOut holds stable while stalled.
REQ-029 ST_SendData: after beat Beats-1 transfers, go to ST_Idle, increment AccessCount, and clear Valid[Index] if the command was ReadRmv.
REQ-030 Back-to-back: a new command may transfer the cycle after returning to ST_Idle; the minimum spacing from one command accept to the next is AccessLatency+Beats+1 cycles for any command.
REQ-031 Beat counter width is log2(Beats), or 1 when Beats=1; it wraps to 0 at the end of each block.
REQ-032 Storage may use registers or inferred RAM; reading it for the snapshot shall not add cycles beyond REQ-024.

Reset
REQ-033 Reset asynchronously sets: FSM=ST_Idle, all Valid bits=0, beat counter=0, latency counter=0, AccessCount=0.
REQ-034 Reset leaves all Ready/Valid outputs at 0 except ORAMCommandReady=1; ORAMDataOut=0; Busy=0.
REQ-035 Reset mid-access aborts it: partial write beats are discarded (Valid unchanged from reset, i.e. 0), and a pending read is dropped.
REQ-036 Storage data contents need not be reset.

Verification (ORAMB=512, FEDWidth=64, NumBlocks=16, AccessLatency=4)
REQ-037 Update addr 0x3 with beats 0x3..0xA, then Read 0x3 -> 8 beats 0x3..0xA in order; AccessCount=2.
REQ-038 Read addr 0x5 after reset -> 8 beats each 64'hdeaf1234deaf1234.
REQ-039 Update 0x7, ReadRmv 0x7, Read 0x7 -> first read returns the written data, second returns the deaf1234 pattern.
REQ-040 Update 0x13 then Read 0x3 -> returns the 0x13 data (index aliasing).
REQ-041 Hold DataOutReady=0 for 10 cycles mid-block -> DataOut/DataOutValid stable; no beat lost or duplicated; CommandReady=0 throughout.
REQ-042 Assert Reset after 3 write beats -> outputs per REQ-034 immediately; a subsequent Read of that address returns the deaf1234 pattern.
